rtic_core: RTL

Real-time input capture core, the receive-side counterpart of the timestamped output core. It watches `DATA_LEN` TTL input lines and detects the selected edges against the shared 64-bit timeline counter. Each detected event is stored as {timestamp, input level} in an internal first-word-fall-through FIFO. Software or the AXI bridge drains the FIFO with the same 128-bit word layout the output core consumes.

---
 rtl/rtic_pkg.sv | 21 ++
 rtl/rtic_fifo.sv | 76 +++++++
 rtl/rtic_core.sv | 116 +++++++++++
 3 files changed

// File: rtl/rtic_pkg.sv
// Shared types and helpers for the real-time input capture core.
// The 128-bit word layout matches what the timestamped output core consumes.
package rtic_pkg;

  localparam int unsigned TS_W  = 64;
  localparam int unsigned OUT_W = 128;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  // level is zero-extended by the caller to TS_W bits
  function automatic logic [OUT_W-1:0] pack_entry(input logic [TS_W-1:0] ts,
                                                  input logic [TS_W-1:0] level);
    return {ts, level};
  endfunction

endpackage

// File: rtl/rtic_fifo.sv
// First-word-fall-through FIFO: the head entry is readable combinationally
// from the register array as soon as the write edge has occurred.
module rtic_fifo
  import rtic_pkg::*;
#(
  parameter int unsigned Depth = 10,
  parameter int unsigned Width = 65
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             srst,
  input  logic             wr_en,
  input  logic [Width-1:0] wdata,
  input  logic             rd_en,
  output logic [Width-1:0] rdata,
  output logic [Depth:0]   count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned      Entries = 2 ** Depth;
  localparam logic [Depth-1:0] PtrOne  = 1;
  localparam logic [Depth:0]   CntOne  = 1;

  logic [Width-1:0] mem_q [Entries];
  logic [Depth-1:0] wr_ptr_q, wr_ptr_d;
  logic [Depth-1:0] rd_ptr_q, rd_ptr_d;
  logic [Depth:0]   count_q, count_d;
  logic             do_wr, do_rd;

  // Occupancy never exceeds Entries, so the MSB alone marks full.
  assign full  = count_q[Depth];
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (srst) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + PtrOne;
      if (do_rd) rd_ptr_d = rd_ptr_q + PtrOne;
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; entries are only observable while non-empty.
  always_ff @(posedge clk) begin
    if (do_wr && !srst) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/rtic_core.sv
// Real-time input capture: synchronizes TTL lines, detects selected edges and
// queues {timestamp, level} entries in a FWFT FIFO with overflow/underflow reporting.
module rtic_core
  import rtic_pkg::*;
#(
  parameter int unsigned DEPTH    = 10,
  parameter int unsigned DATA_LEN = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                auto_start,
  input  logic                flush,
  input  logic [1:0]          edge_mode,
  input  logic [DATA_LEN-1:0] ttl_in,
  input  logic [TS_W-1:0]     counter,
  input  logic                read,
  output logic [OUT_W-1:0]    rtic_out,
  output logic                empty,
  output logic                full,
  output logic [DEPTH:0]      fifo_count,
  output logic                overflow_error,
  output logic [OUT_W-1:0]    overflow_error_data,
  output logic                underflow_error
);

  localparam int unsigned EntW = TS_W + DATA_LEN;

  logic [DATA_LEN-1:0] sync1_q, sync2_q;
  logic [DATA_LEN-1:0] prev_q, prev_d;
  logic                armed_q, armed_d;
  logic                ovf_q, ovf_d;
  logic [OUT_W-1:0]    ovf_data_q, ovf_data_d;
  logic                unf_q, unf_d;

  logic [DATA_LEN-1:0] rise, fall, masked;
  logic                evt, pop, push, drop;
  logic [TS_W-1:0]     in_level, out_level;
  logic [EntW-1:0]     fifo_rdata;
  logic                fifo_empty, fifo_full;

  // Synchronizer flops run freely through reset so they already hold the
  // settled line level when reset releases.
  always_ff @(posedge clk) begin
    sync1_q <= ttl_in;
    sync2_q <= sync1_q;
  end

  always_comb begin
    rise = sync2_q & ~prev_q;
    fall = ~sync2_q & prev_q;
    case (edge_mode_t'(edge_mode))
      EDGE_RISE: masked = rise;
      EDGE_FALL: masked = fall;
      EDGE_BOTH: masked = rise | fall;
      default:   masked = '0;
    endcase

    evt  = auto_start & armed_q & (|masked);
    pop  = read & ~fifo_empty;
    push = evt & (~fifo_full | pop);
    drop = evt & fifo_full & ~pop;

    in_level                 = '0;
    in_level[DATA_LEN-1:0]   = sync2_q;
    out_level                = '0;
    out_level[DATA_LEN-1:0]  = fifo_rdata[DATA_LEN-1:0];

    prev_d     = sync2_q;
    armed_d    = 1'b1;
    ovf_d      = drop;
    ovf_data_d = drop ? pack_entry(counter, in_level) : ovf_data_q;
    unf_d      = read & fifo_empty;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q     <= '0;
      armed_q    <= 1'b0;
      ovf_q      <= 1'b0;
      ovf_data_q <= '0;
      unf_q      <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      armed_q    <= armed_d;
      ovf_q      <= ovf_d;
      ovf_data_q <= ovf_data_d;
      unf_q      <= unf_d;
    end
  end

  rtic_fifo #(
    .Depth (DEPTH),
    .Width (EntW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .srst  (flush),
    .wr_en (push),
    .wdata ({counter, sync2_q}),
    .rd_en (read),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign empty               = fifo_empty;
  assign full                = fifo_full;
  // Stale storage is masked so the output reads zero whenever nothing is queued.
  assign rtic_out            = fifo_empty ? '0
                             : pack_entry(fifo_rdata[EntW-1:DATA_LEN], out_level);
  assign overflow_error      = ovf_q;
  assign overflow_error_data = ovf_data_q;
  assign underflow_error     = unf_q;

endmodule
